// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer plus trap-entry / MRET sequences in front of the M-mode CSR file.
// Build option CSR_MTVAL_EN: when defined, trap entry also writes mtval (one extra write cycle).
module csr_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic [11:0] reqAddr,
  input  logic [31:0] reqRs1Data,
  input  logic [4:0]  reqZimm,
  input  logic        reqSrcZero,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspIllegal,
  input  logic        trapValid,
  output logic        trapReady,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapPc,
  input  logic [31:0] trapValue,
  input  logic        mretValid,
  output logic        mretReady,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic [3:0]  csrReadIndex,
  input  logic [31:0] csrReadData,
  output logic [3:0]  csrWriteIndex,
  output logic [31:0] csrWriteData,
  output logic        csrWriteEnable
);

  typedef enum logic [2:0] {
    IDLE,
    CSR_WB,
    TRAP_MEPC,
    TRAP_MCAUSE,
`ifdef CSR_MTVAL_EN
    TRAP_MTVAL,
`endif
    TRAP_MSTATUS,
    MRET_MSTATUS
  } state_t;

  localparam logic [3:0] IDX_MSTATUS = 4'd0;
  localparam logic [3:0] IDX_MTVEC   = 4'd2;
  localparam logic [3:0] IDX_MEPC    = 4'd4;
  localparam logic [3:0] IDX_MCAUSE  = 4'd5;
  localparam logic [3:0] IDX_MTVAL   = 4'd6;
  localparam logic [3:0] IDX_MISA    = 4'd8;

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] trap_target_q, trap_target_d;
  logic [31:0] cause_q, cause_d;
  logic [3:0]  wr_index_q, wr_index_d;
  logic [31:0] wr_data_q, wr_data_d;
`ifdef CSR_MTVAL_EN
  logic [31:0] value_q, value_d;
`else
  logic        unused_trap_value;
  assign unused_trap_value = ^trapValue;
`endif

  logic        map_hit;
  logic [3:0]  map_index;
  logic [31:0] req_src;
  logic [31:0] req_new;
  logic        req_writes;
  logic [31:0] trap_base;
  logic        trap_vectored;
  logic [31:0] trap_target;
  logic [3:0]  read_index;
  logic [31:0] mstatus_new;
  logic        mstatus_phase;
  logic        idle_ready;

  always_comb begin
    map_hit   = 1'b1;
    map_index = 4'd0;
    case (reqAddr)
      12'h300: map_index = 4'd0;
      12'h304: map_index = 4'd1;
      12'h305: map_index = 4'd2;
      12'h340: map_index = 4'd3;
      12'h341: map_index = 4'd4;
      12'h342: map_index = 4'd5;
      12'h343: map_index = 4'd6;
      12'h344: map_index = 4'd7;
      12'h301: map_index = 4'd8;
      default: map_hit   = 1'b0;
    endcase
  end

  // Read-modify-write operand; reqOp[2] selects the zero-extended immediate.
  always_comb begin
    req_src = reqOp[2] ? {27'd0, reqZimm} : reqRs1Data;
    case (reqOp[1:0])
      2'b01:   req_new = req_src;
      2'b10:   req_new = csrReadData | req_src;
      2'b11:   req_new = csrReadData & ~req_src;
      default: req_new = csrReadData;
    endcase
    // Set/clear with a zero source is a pure read; misa writes are dropped.
    req_writes = map_hit && (reqOp[1:0] != 2'b00) && !(reqOp[1] && reqSrcZero)
                 && (map_index != IDX_MISA);
  end

  always_comb begin
    trap_base     = {csrReadData[31:2], 2'b00};
    trap_vectored = (csrReadData[1:0] == 2'b01) && trapCause[31];
    trap_target   = trap_vectored ? trap_base + {trapCause[29:0], 2'b00} : trap_base;
  end

  assign idle_ready    = (state_q == IDLE) && !reset;
  assign mstatus_phase = (state_q == TRAP_MSTATUS) || (state_q == MRET_MSTATUS);

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    redirect_pc_d = redirect_pc_q;
    trap_target_d = trap_target_q;
    cause_d       = cause_q;
    wr_index_d    = wr_index_q;
    wr_data_d     = wr_data_q;
`ifdef CSR_MTVAL_EN
    value_d       = value_q;
`endif
    read_index    = IDX_MSTATUS;
    mstatus_new   = csrReadData;

    case (state_q)
      IDLE: begin
        if (trapValid) begin
          read_index    = IDX_MTVEC;
          trap_target_d = trap_target;
          cause_d       = trapCause;
`ifdef CSR_MTVAL_EN
          value_d       = trapValue;
`endif
          wr_index_d    = IDX_MEPC;
          wr_data_d     = {trapPc[31:2], 2'b00};
          state_d       = TRAP_MEPC;
        end else if (mretValid) begin
          read_index    = IDX_MEPC;
          redirect_pc_d = csrReadData;
          wr_index_d    = IDX_MSTATUS;
          state_d       = MRET_MSTATUS;
        end else begin
          read_index = map_index;
          if (reqValid) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = map_hit ? csrReadData : 32'd0;
            rsp_illegal_d = !map_hit;
            if (req_writes) begin
              wr_index_d = map_index;
              wr_data_d  = req_new;
              state_d    = CSR_WB;
            end
          end
        end
      end
      CSR_WB: state_d = IDLE;
      TRAP_MEPC: begin
        wr_index_d = IDX_MCAUSE;
        wr_data_d  = cause_q;
        state_d    = TRAP_MCAUSE;
      end
`ifdef CSR_MTVAL_EN
      TRAP_MCAUSE: begin
        wr_index_d = IDX_MTVAL;
        wr_data_d  = value_q;
        state_d    = TRAP_MTVAL;
      end
      TRAP_MTVAL: begin
        wr_index_d    = IDX_MSTATUS;
        redirect_pc_d = trap_target_q;
        state_d       = TRAP_MSTATUS;
      end
`else
      TRAP_MCAUSE: begin
        wr_index_d    = IDX_MSTATUS;
        redirect_pc_d = trap_target_q;
        state_d       = TRAP_MSTATUS;
      end
`endif
      // mstatus is read and rewritten in the same cycle, so its data bypasses wr_data_q.
      TRAP_MSTATUS: begin
        mstatus_new[7]     = csrReadData[3];
        mstatus_new[3]     = 1'b0;
        mstatus_new[12:11] = 2'b11;
        state_d            = IDLE;
      end
      MRET_MSTATUS: begin
        mstatus_new[3]     = csrReadData[7];
        mstatus_new[7]     = 1'b1;
        mstatus_new[12:11] = 2'b11;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_illegal_q <= 1'b0;
      redirect_pc_q <= 32'd0;
      trap_target_q <= 32'd0;
      cause_q       <= 32'd0;
      wr_index_q    <= 4'd0;
      wr_data_q     <= 32'd0;
`ifdef CSR_MTVAL_EN
      value_q       <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
      redirect_pc_q <= redirect_pc_d;
      trap_target_q <= trap_target_d;
      cause_q       <= cause_d;
      wr_index_q    <= wr_index_d;
      wr_data_q     <= wr_data_d;
`ifdef CSR_MTVAL_EN
      value_q       <= value_d;
`endif
    end
  end

  assign trapReady      = idle_ready;
  assign mretReady      = idle_ready && !trapValid;
  assign reqReady       = idle_ready && !trapValid && !mretValid;
  assign rspValid       = rsp_valid_q && !reset;
  assign rspData        = rsp_data_q;
  assign rspIllegal     = rsp_illegal_q;
  assign redirectValid  = mstatus_phase && !reset;
  assign redirectPc     = redirect_pc_q;
  assign csrReadIndex   = read_index;
  assign csrWriteEnable = (state_q != IDLE) && !reset;
  assign csrWriteIndex  = wr_index_q;
  assign csrWriteData   = mstatus_phase ? mstatus_new : wr_data_q;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer on the requester side of the machine-mode CSR register file. It executes Zicsr instructions as read-modify-write operations and runs the multi-cycle trap-entry and MRET sequences. It drives the file's single combinational read port and single write port, and returns old values and PC redirects to the pipeline. All CSR write traffic goes through this block; it also maps 12-bit CSR addresses to the file's 4-bit indices.

## Interface
- Parameters: none.
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reqValid / reqReady  in / out  1  Zicsr request handshake.
- reqOp  in  3  funct3 encoding:
  - 001 RW, 010 RS, 011 RC.
  - 101 RWI, 110 RSI, 111 RCI.
- reqAddr  in  12  CSR address.
- reqRs1Data  in  32  register operand.
- reqZimm  in  5  immediate operand.
- reqSrcZero  in  1  rs1 index (or zimm) is zero.
- rspValid  out  1  one-cycle response pulse.
- rspData  out  32  old CSR value.
- rspIllegal  out  1  unmapped address.
- trapValid / trapReady  in / out  1  trap-entry handshake.
- trapCause, trapPc, trapValue  in  32 each  mcause, faulting PC, mtval.
- mretValid / mretReady  in / out  1  MRET handshake.
- redirectValid  out  1  one-cycle pulse.
- redirectPc  out  32  new fetch PC.
- csrReadIndex  out  4  read-port index.
- csrReadData  in  32  same-cycle read data.
- csrWriteIndex  out  4  write-port index.
- csrWriteData  out  32  write data.
- csrWriteEnable  out  1  write strobe.

## Operation
- Index map (anything else is illegal):
  - mstatus 0x300→0, mie 0x304→1, mtvec 0x305→2, mscratch 0x340→3.
  - mepc 0x341→4, mcause 0x342→5, mtval 0x343→6, mip 0x344→7, misa 0x301→8.
- States: IDLE, CSR_WB, TRAP_MEPC, TRAP_MCAUSE, TRAP_MTVAL, TRAP_MSTATUS, MRET_MSTATUS.
- Ready signals:
  - trapReady = IDLE.
  - mretReady = IDLE & !trapValid.
  - reqReady = IDLE & !trapValid & !mretValid.
- Arbitration priority: trap > mret > request.
- Read index in IDLE: 2 (mtvec) if trapValid, else 4 (mepc) if mretValid, else the mapped reqAddr (0 if unmapped).
- Request accepted in IDLE:
  - Latch old = csrReadData.
  - Source is reqRs1Data, or zero-extended reqZimm for the I-variants.
  - New value: RW = src; RS = old | src; RC = old & ~src.
- Request outcome:
  - Illegal: no write.
  - No write for RS/RC with reqSrcZero.
  - No write to misa (read-only; the write is silently dropped).
  - Otherwise go to CSR_WB: csrWriteEnable = 1 for one cycle, then IDLE.
- Trap accept:
  - Latch mtvec, cause, PC, and value.
  - TRAP_MEPC writes idx 4 = trapPc & ~3.
  - TRAP_MCAUSE writes idx 5 = cause.
  - TRAP_MTVAL writes idx 6 = value (see Configuration).
  - TRAP_MSTATUS: read idx 0, then write with MPIE = MIE (bit3 → bit7), MIE = 0, MPP[12:11] = 11.
- Trap redirect target:
  - Base = mtvec & ~3.
  - If mtvec[1:0] = 01 and cause[31] = 1: base + 4 * cause[30:0], truncated to 32 bits.
  - Else: base.
- MRET accept:
  - Latch mepc.
  - MRET_MSTATUS: read idx 0, then write with MIE = MPIE, MPIE = 1, MPP = 11.
  - redirectPc = latched mepc.
- Write-index source: csrWriteIndex/csrWriteData are registered. csrReadIndex is combinational from state and inputs.

## Timing
- Reset: state IDLE. All of these are 0:
  - rspValid, rspData, rspIllegal.
  - redirectValid, redirectPc.
  - csrWriteEnable, csrWriteIndex, csrWriteData.
- Ready signals are 0 during a reset cycle.
- Request accepted in cycle N:
  - rspValid at N+1 in all cases.
  - Write (if any) at N+1.
  - reqReady is low at N+1 only when a write occurs.
  - Back-to-back requests without a write: one accepted per cycle.
- Trap accepted at N:
  - Writes at N+1 (mepc), N+2 (mcause), N+3 (mtval).
  - mstatus write plus redirectValid at N+4.
  - IDLE at N+5.
- MRET accepted at N: mstatus write plus redirectValid at N+1; IDLE at N+2.
- Simultaneous trapValid and reqValid in IDLE: trap wins. The request is not accepted and must be held by its source.
- Reset in any non-IDLE state: return to IDLE next cycle. No further writes, no rspValid, no redirectValid.
- Inputs are sampled only on the accept cycle. Changes during a sequence are ignored.

## Configuration
- CSR_MTVAL_EN:
  - Defined: TRAP_MTVAL exists. Trap entry takes 4 write cycles; redirect at N+4.
  - Undefined: TRAP_MTVAL is removed and trapValue is ignored. TRAP_MCAUSE goes directly to TRAP_MSTATUS; redirect at N+3. mtval is never written by traps.

## Test plan
- CSRRW 0x340 (mscratch), rs1 = 0xDEADBEEF, mscratch = 0x12345678 → at N+1: rspData = 0x12345678, write idx 3 = 0xDEADBEEF; reqReady low at N+1.
- CSRRS 0x300 with reqSrcZero = 1, mstatus = 0x1800 → rspData = 0x1800; csrWriteEnable never asserts; reqReady stays high.
- CSRRW 0x7C0 → rspValid with rspIllegal = 1; no write. CSRRW 0x301 → rspData = 0x40000100; no write.
- Trap: cause 2, pc 0x80000106, value 0x13, mtvec 0x00000100, mstatus 0x1808 →
  - mepc = 0x80000104, mcause = 2, mtval = 0x13.
  - mstatus = 0x1880.
  - redirectPc = 0x100 at N+4 (N+3 without CSR_MTVAL_EN).
- Vectored interrupt: mtvec 0x00000101, cause 0x80000007 → redirectPc = 0x0000011C.
- trapValid and reqValid asserted together → trap sequence runs first; the request is accepted only after the trap returns to IDLE. Then MRET with mstatus 0x1880, mepc 0x200 → mstatus = 0x1888, redirectPc = 0x200. Reset asserted at N+2 of a trap → no mcause write and no redirect.
